// File: rtl/ysyx_22050710_lsu_pkg.sv
// Shared definitions for the NPC load/store unit: MemOP encodings, FSM states
// and access-size decode.
package ysyx_22050710_lsu_pkg;

  localparam logic [2:0] MEMOP_B   = 3'b000;
  localparam logic [2:0] MEMOP_H   = 3'b001;
  localparam logic [2:0] MEMOP_W   = 3'b010;
  localparam logic [2:0] MEMOP_D   = 3'b011;
  localparam logic [2:0] MEMOP_BU  = 3'b100;
  localparam logic [2:0] MEMOP_HU  = 3'b101;
  localparam logic [2:0] MEMOP_WU  = 3'b110;
  localparam logic [2:0] MEMOP_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  function automatic lsu_size_e size_of(input logic [2:0] op);
    return lsu_size_e'(op[1:0]);
  endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Combinational lane logic: legality/alignment check and store lane placement
// for the incoming operation, plus load extraction/extension for the response.
module ysyx_22050710_lsu_align
  import ysyx_22050710_lsu_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [2:0]  op,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [63:0] wdata,
  output logic        err,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_lane,
  input  logic [2:0]  rsp_off,
  input  logic [2:0]  rsp_op,
  input  logic [63:0] mem_rdata,
  output logic [63:0] rdata_ext
);

  logic       misaligned_s;
  logic [7:0] base_mask_s;
  logic [63:0] shifted_s;

  // Request side: alignment by access size, byte enables and shifted store data
  always_comb begin
    misaligned_s = 1'b0;
    base_mask_s  = 8'h01;
    case (size_of(op))
      SZ_B: begin misaligned_s = 1'b0;             base_mask_s = 8'h01; end
      SZ_H: begin misaligned_s = off[0];           base_mask_s = 8'h03; end
      SZ_W: begin misaligned_s = (off[1:0] != 2'b00); base_mask_s = 8'h0F; end
      SZ_D: begin misaligned_s = (off != 3'b000);  base_mask_s = 8'hFF; end
      default: begin misaligned_s = 1'b1;          base_mask_s = 8'h00; end
    endcase
    // Unsigned MemOPs have no store meaning, so op[2] is illegal on a write.
    err = (rd_en && wr_en)
       || ((rd_en || wr_en) && (misaligned_s || (op == MEMOP_ILL)))
       || (wr_en && op[2]);
    wmask      = base_mask_s << off;
    wdata_lane = wdata << {off, 3'b000};
  end

  // Response side: bring the addressed bytes down to bit 0, then extend
  always_comb begin
    shifted_s = mem_rdata >> {rsp_off, 3'b000};
    case (rsp_op)
      MEMOP_B:  rdata_ext = {{56{shifted_s[7]}},  shifted_s[7:0]};
      MEMOP_H:  rdata_ext = {{48{shifted_s[15]}}, shifted_s[15:0]};
      MEMOP_W:  rdata_ext = {{32{shifted_s[31]}}, shifted_s[31:0]};
      MEMOP_D:  rdata_ext = shifted_s;
      MEMOP_BU: rdata_ext = {56'd0, shifted_s[7:0]};
      MEMOP_HU: rdata_ext = {48'd0, shifted_s[15:0]};
      MEMOP_WU: rdata_ext = {32'd0, shifted_s[31:0]};
      default:  rdata_ext = 64'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050710_lsu.sv
// Multi-cycle load/store unit: one operation at a time from the EXU, carried
// over a req/gnt/rvalid data-memory bus, result handed to write-back.
module ysyx_22050710_lsu
  import ysyx_22050710_lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_MemOP,
  input  logic        i_RdEn,
  input  logic        i_WrEn,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_rdata,
  output logic        o_err,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic [63:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_wmask,
  input  logic        i_mem_rvalid,
  input  logic [63:0] i_mem_rdata
);

  lsu_state_e  state_r, state_nxt_s;
  logic [63:0] addr_r, wdata_r, rdata_r;
  logic [7:0]  wmask_r;
  logic [2:0]  op_r, off_r;
  logic        we_r, rd_r, err_r;

  logic        err_s;
  logic [7:0]  wmask_s;
  logic [63:0] wdata_lane_s, rdata_ext_s;

  ysyx_22050710_lsu_align u_align (
    .off        (i_addr[2:0]),
    .op         (i_MemOP),
    .rd_en      (i_RdEn),
    .wr_en      (i_WrEn),
    .wdata      (i_wdata),
    .err        (err_s),
    .wmask      (wmask_s),
    .wdata_lane (wdata_lane_s),
    .rsp_off    (off_r),
    .rsp_op     (op_r),
    .mem_rdata  (i_mem_rdata),
    .rdata_ext  (rdata_ext_s)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state; errors and no-ops skip the bus entirely
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          if (err_s || !(i_RdEn || i_WrEn)) state_nxt_s = ST_DONE;
          else                              state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_mem_gnt) state_nxt_s = ST_RSP;
        else           state_nxt_s = ST_REQ;
      end
      ST_RSP: begin
        if (i_mem_rvalid) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_RSP;
      end
      ST_DONE: begin
        if (i_ready) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Capture the operation at accept; latch load data when the response lands
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      addr_r  <= 64'd0;
      wdata_r <= 64'd0;
      rdata_r <= 64'd0;
      wmask_r <= 8'd0;
      op_r    <= 3'd0;
      off_r   <= 3'd0;
      we_r    <= 1'b0;
      rd_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            addr_r  <= {i_addr[63:3], 3'b000};
            off_r   <= i_addr[2:0];
            op_r    <= i_MemOP;
            rd_r    <= i_RdEn && !err_s;
            we_r    <= i_WrEn && !err_s;
            wmask_r <= (i_WrEn && !err_s) ? wmask_s : 8'd0;
            wdata_r <= (i_WrEn && !err_s) ? wdata_lane_s : 64'd0;
            err_r   <= err_s;
            rdata_r <= 64'd0;
          end
        end
        ST_RSP: begin
          if (i_mem_rvalid && rd_r) rdata_r <= rdata_ext_s;
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = (state_r == ST_IDLE);
  assign o_mem_req   = (state_r == ST_REQ);
  assign o_valid     = (state_r == ST_DONE);
  assign o_rdata     = rdata_r;
  assign o_err       = err_r;
  assign o_mem_addr  = addr_r;
  assign o_mem_we    = we_r;
  assign o_mem_wdata = wdata_r;
  assign o_mem_wmask = wmask_r;

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// Self-checking bench for ysyx_22050710_lsu: directed table, reset-mid-RSP
// sequence and randomized operations against a byte-level reference model.
module tb_ysyx_22050710_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_RdEn, i_WrEn, i_ready, i_mem_gnt, i_mem_rvalid;
  logic [63:0] i_addr, i_wdata, i_mem_rdata;
  logic [2:0]  i_MemOP;
  logic        o_ready, o_valid, o_err, o_mem_req, o_mem_we;
  logic [63:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wmask;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] MEM = 64'h8877_6655_4433_2211;

  ysyx_22050710_lsu dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_MemOP(i_MemOP),
    .i_RdEn(i_RdEn), .i_WrEn(i_WrEn), .o_valid(o_valid), .i_ready(i_ready),
    .o_rdata(o_rdata), .o_err(o_err), .o_mem_req(o_mem_req),
    .i_mem_gnt(i_mem_gnt), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mem;
    logic [2:0]  op;
    logic        rd;
    logic        wr;
    int          gd;
    int          rv;
    int          rdy;
    logic        err;
    logic        bus;
    logic [63:0] rdata;
    logic [7:0]  mask;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string tag, input string what, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got 0x%016h expected 0x%016h", tag, what, got, exp);
    end
  endtask

  // Reference: size = 2^op[1:0] bytes, offset = addr mod 8, bytes taken little-endian.
  function automatic void model(input logic [63:0] addr, input logic [63:0] mem,
                                input logic [2:0] op, input logic rd, input logic wr,
                                output logic err, output logic bus,
                                output logic [63:0] rdata, output logic [7:0] mask);
    int n, off;
    logic [63:0] v, lim;
    n = 1 << op[1:0];
    off = int'(addr[2:0]);
    err = 1'b0;
    if (rd && wr) err = 1'b1;
    else if (rd || wr) begin
      if (op == 3'd7) err = 1'b1;
      if (wr && op >= 3'd4) err = 1'b1;
      if ((off % n) != 0) err = 1'b1;
    end
    bus = (rd || wr) && !err;
    rdata = 64'd0;
    mask = 8'd0;
    if (bus && rd) begin
      v = mem >> (8 * off);
      if (n < 8) begin
        lim = (64'd1 << (8 * n)) - 64'd1;
        v = v & lim;
        if (op < 3'd4 && v[8*n-1]) v = v | ~lim;
      end
      rdata = v;
    end
    if (bus && wr) mask = 8'(((1 << n) - 1) << off);
  endfunction

  task automatic run_op(input string tag, input vec_t t);
    int ph, ng, nr, nv, off;
    logic seen_req, seen_valid, e0;
    logic [63:0] r0;
    ph = 0; ng = 0; nr = 0; nv = 0;
    seen_req = 1'b0; seen_valid = 1'b0; e0 = 1'b0; r0 = 64'd0;
    off = int'(t.addr[2:0]);
    @(negedge i_clk);
    chk(tag, "ready_before", {63'd0, o_ready}, 64'd1);
    i_valid = 1'b1; i_addr = t.addr; i_wdata = t.wdata; i_MemOP = t.op;
    i_RdEn = t.rd; i_WrEn = t.wr;
    for (int c = 0; c < 200 && ph != 4; c++) begin
      @(negedge i_clk);
      i_valid = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_ready = 1'b0;
      i_mem_rdata = {$urandom, $urandom};
      if (ph == 3) begin
        chk(tag, "turnaround", {62'd0, o_ready, o_valid}, 64'd2);
        ph = 4;
      end else if (o_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1; r0 = o_rdata; e0 = o_err;
          chk(tag, "latency", 64'(c + 1), t.bus ? 64'(t.gd + t.rv + 3) : 64'd1);
          chk(tag, "rdata", o_rdata, t.rdata);
          chk(tag, "err", {63'd0, o_err}, {63'd0, t.err});
          chk(tag, "bus_used", {63'd0, seen_req}, {63'd0, t.bus});
        end else begin
          chk(tag, "rdata_hold", o_rdata, r0);
          chk(tag, "err_hold", {63'd0, o_err}, {63'd0, e0});
        end
        chk(tag, "ready_low", {63'd0, o_ready}, 64'd0);
        if (nv == t.rdy) begin i_ready = 1'b1; ph = 3; end
        nv++;
      end else if (o_mem_req) begin
        seen_req = 1'b1;
        chk(tag, "mem_addr", o_mem_addr, {t.addr[63:3], 3'b000});
        chk(tag, "mem_we", {63'd0, o_mem_we}, {63'd0, t.wr});
        if (t.wr) chk(tag, "wmask", {56'd0, o_mem_wmask}, {56'd0, t.mask});
        for (int j = 0; j < 8; j++)
          if (t.wr && t.mask[j])
            chk(tag, "wdata_byte", {56'd0, o_mem_wdata[8*j +: 8]}, {56'd0, t.wdata[8*(j-off) +: 8]});
        chk(tag, "ready_low", {63'd0, o_ready}, 64'd0);
        if (ng == t.gd) begin i_mem_gnt = 1'b1; ph = 1; end
        ng++;
      end else if (ph == 1) begin
        chk(tag, "ready_low", {63'd0, o_ready}, 64'd0);
        if (nr == t.rv) begin i_mem_rvalid = 1'b1; i_mem_rdata = t.mem; end
        nr++;
      end
    end
    if (ph != 4) chk(tag, "timeout", 64'd0, 64'd1);
  endtask

  initial begin
    vec_t rv;
    int kind;
    i_rst = 1'b0; i_valid = 1'b0; i_RdEn = 1'b0; i_WrEn = 1'b0; i_ready = 1'b0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_addr = 64'd0; i_wdata = 64'd0;
    i_mem_rdata = 64'd0; i_MemOP = 3'd0;

    tbl[0]  = '{64'h1007, 64'h0, MEM, 3'd0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF88, 8'h00};
    tbl[1]  = '{64'h1006, 64'h0, MEM, 3'd5, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 64'h0000_0000_0000_8877, 8'h00};
    tbl[2]  = '{64'h2004, 64'hDEADBEEF, MEM, 3'd2, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1, 64'h0, 8'hF0};
    tbl[3]  = '{64'h1002, 64'h0, MEM, 3'd2, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0, 64'h0, 8'h00};
    tbl[4]  = '{64'h1000, 64'h0, MEM, 3'd7, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0, 64'h0, 8'h00};
    tbl[5]  = '{64'h1000, 64'h0, MEM, 3'd3, 1'b1, 1'b0, 5, 3, 2, 1'b0, 1'b1, MEM, 8'h00};
    tbl[6]  = '{64'h1004, 64'h0, MEM, 3'd2, 1'b1, 1'b0, 1, 0, 1, 1'b0, 1'b1, 64'hFFFF_FFFF_8877_6655, 8'h00};
    tbl[7]  = '{64'h1004, 64'h0, MEM, 3'd6, 1'b1, 1'b0, 0, 2, 0, 1'b0, 1'b1, 64'h0000_0000_8877_6655, 8'h00};
    tbl[8]  = '{64'h2003, 64'hAB, MEM, 3'd0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1, 64'h0, 8'h08};
    tbl[9]  = '{64'h2008, 64'h0123_4567_89AB_CDEF, MEM, 3'd3, 1'b0, 1'b1, 2, 1, 1, 1'b0, 1'b1, 64'h0, 8'hFF};
    tbl[10] = '{64'h1000, 64'h0, MEM, 3'd3, 1'b1, 1'b1, 0, 0, 0, 1'b1, 1'b0, 64'h0, 8'h00};
    tbl[11] = '{64'h1003, 64'h5, MEM, 3'd2, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0, 64'h0, 8'h00};
    tbl[12] = '{64'h2000, 64'h11, MEM, 3'd4, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 64'h0, 8'h00};
    tbl[13] = '{64'h2001, 64'h1234, MEM, 3'd1, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 64'h0, 8'h00};
    tbl[14] = '{64'h1002, 64'h0, MEM, 3'd1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 64'h0000_0000_0000_4433, 8'h00};
    tbl[15] = '{64'h1007, 64'h0, MEM, 3'd4, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 64'h0000_0000_0000_0088, 8'h00};

    repeat (3) @(negedge i_clk);
    chk("reset", "o_valid", {63'd0, o_valid}, 64'd0);
    chk("reset", "o_mem_req", {63'd0, o_mem_req}, 64'd0);
    chk("reset", "o_err", {63'd0, o_err}, 64'd0);
    chk("reset", "o_rdata", o_rdata, 64'd0);
    chk("reset", "o_mem_we", {63'd0, o_mem_we}, 64'd0);
    chk("reset", "o_mem_wmask", {56'd0, o_mem_wmask}, 64'd0);
    i_rst = 1'b1;

    for (int i = 0; i < 16; i++) run_op($sformatf("tbl%0d", i), tbl[i]);

    // Reset while waiting for the response; a late rvalid must be dropped.
    @(negedge i_clk);
    i_valid = 1'b1; i_addr = 64'h3000; i_MemOP = 3'd3; i_RdEn = 1'b1; i_WrEn = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("rstmid", "req", {63'd0, o_mem_req}, 64'd1);
    i_mem_gnt = 1'b1;
    @(negedge i_clk);
    i_mem_gnt = 1'b0;
    chk("rstmid", "in_rsp", {62'd0, o_mem_req, o_valid}, 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    chk("rstmid", "ready", {63'd0, o_ready}, 64'd1);
    chk("rstmid", "outs", {59'd0, o_valid, o_mem_req, o_err, o_mem_we, |o_mem_wmask}, 64'd0);
    chk("rstmid", "rdata", o_rdata, 64'd0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'hCAFE_F00D_1234_5678;
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    chk("rstmid", "late_rsp", {62'd0, o_ready, o_valid}, 64'd2);
    chk("rstmid", "rdata_late", o_rdata, 64'd0);
    run_op("rstmid_ld", '{64'h3000, 64'h0, 64'hCAFE_F00D_1234_5678, 3'd3, 1'b1, 1'b0, 0, 0, 0,
                          1'b0, 1'b1, 64'hCAFE_F00D_1234_5678, 8'h00});

    for (int i = 0; i < 300; i++) begin
      rv.op = 3'($urandom_range(0, 7));
      kind = int'($urandom_range(0, 9));
      rv.rd = (kind == 1) || (kind >= 2 && kind <= 5);
      rv.wr = (kind == 1) || (kind >= 6);
      rv.addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0)
        rv.addr = rv.addr & ~((64'd1 << rv.op[1:0]) - 64'd1);
      rv.wdata = {$urandom, $urandom};
      rv.mem = {$urandom, $urandom};
      rv.gd = int'($urandom_range(0, 3));
      rv.rv = int'($urandom_range(0, 3));
      rv.rdy = int'($urandom_range(0, 2));
      model(rv.addr, rv.mem, rv.op, rv.rd, rv.wr, rv.err, rv.bus, rv.rdata, rv.mask);
      run_op($sformatf("rnd%0d", i), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
